// File: rtl/state_dump_pkg.sv
// Shared constants for the end-of-run state dump: FSM states, record tags and halt causes.
package state_dump_pkg;

   typedef logic [1:0] state_t;

   localparam state_t RUN      = 2'd0;
   localparam state_t DUMP_REG = 2'd1;
   localparam state_t DUMP_MEM = 2'd2;
   localparam state_t DONE     = 2'd3;

   localparam logic [1:0] TAG_PC  = 2'd0;
   localparam logic [1:0] TAG_REG = 2'd1;
   localparam logic [1:0] TAG_MEM = 2'd2;

   localparam logic [1:0] CAUSE_NONE      = 2'd0;
   localparam logic [1:0] CAUSE_ZERO_INST = 2'd1;
   localparam logic [1:0] CAUSE_TIMEOUT   = 2'd2;

   localparam int NUM_REGS = 32;

endpackage

// File: rtl/dump_out_stage.sv
// Single-register valid/ready output stage for dump records.
module dump_out_stage
   import state_dump_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load_en,
   input  logic [1:0]  load_tag,
   input  logic [31:0] load_data,
   input  logic        load_last,
   input  logic        out_ready,
   output logic        can_load,
   output logic        out_valid,
   output logic [1:0]  out_tag,
   output logic [31:0] out_data,
   output logic        out_last
);

   assign can_load = !out_valid || out_ready;

   // A free or draining slot takes the new record; with nothing offered, valid simply drops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_tag   <= TAG_PC;
         out_data  <= 32'd0;
         out_last  <= 1'b0;
      end else if (can_load) begin
         out_valid <= load_en;
         if (load_en) begin
            out_tag  <= load_tag;
            out_data <= load_data;
            out_last <= load_last;
         end
      end
   end

endmodule

// File: rtl/state_dump_unit.sv
// Halts the machine on a zero instruction or timeout, then streams all registers and a memory window.
// Optional PC trace records during RUN are enabled by defining STATE_DUMP_PC_TRACE_EN.
module state_dump_unit
   import state_dump_pkg::*;
#(
   parameter logic [31:0] MEM_BASE       = 32'h4000,
   parameter int          MEM_WORDS      = 4,
   parameter int          TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] inst,
   input  logic [31:0] pc,
   output logic        halt_req,
   output logic [4:0]  rf_raddr,
   input  logic [31:0] rf_rdata,
   output logic [31:0] mem_raddr,
   input  logic [7:0]  mem_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [1:0]  out_tag,
   output logic [31:0] out_data,
   output logic        out_last,
   output logic [1:0]  halt_cause,
   output logic        done
`ifdef STATE_DUMP_PC_TRACE_EN
   ,
   output logic        trace_overflow
`endif
);

   localparam logic [8:0]  LAST_MEM     = 9'(MEM_WORDS - 1);
   localparam logic [8:0]  LAST_REG     = 9'(NUM_REGS - 1);
   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

   state_t      state;
   logic [31:0] count;
   logic [8:0]  index;
   logic        zero_inst;
   logic        timeout;
   logic        can_load;
   logic        load_en;
   logic [1:0]  load_tag;
   logic [31:0] load_data;
   logic        load_last;

   assign zero_inst = (inst == 32'd0);
   assign timeout   = (count == TIMEOUT_LAST);
   assign rf_raddr  = (state == DUMP_REG) ? index[4:0] : 5'd0;
   assign mem_raddr = MEM_BASE + {23'd0, index};

   // Index runs one past the last byte in DUMP_MEM, which stops further loads until the final handshake.
   always_comb begin
      load_en   = 1'b0;
      load_tag  = TAG_REG;
      load_data = 32'd0;
      load_last = 1'b0;
      case (state)
         RUN: begin
`ifdef STATE_DUMP_PC_TRACE_EN
            load_en   = 1'b1;
            load_tag  = TAG_PC;
            load_data = pc;
`endif
         end
         DUMP_REG: begin
            load_en   = 1'b1;
            load_tag  = TAG_REG;
            load_data = rf_rdata;
         end
         DUMP_MEM: begin
            load_en   = (index <= LAST_MEM);
            load_tag  = TAG_MEM;
            load_data = {24'd0, mem_rdata};
            load_last = (index == LAST_MEM);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= RUN;
         count      <= 32'd0;
         index      <= 9'd0;
         halt_req   <= 1'b0;
         halt_cause <= CAUSE_NONE;
         done       <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               count <= count + 32'd1;
               if (zero_inst || timeout) begin
                  state      <= DUMP_REG;
                  halt_req   <= 1'b1;
                  index      <= 9'd0;
                  halt_cause <= zero_inst ? CAUSE_ZERO_INST : CAUSE_TIMEOUT;
               end
            end
            DUMP_REG: begin
               if (can_load) begin
                  if (index == LAST_REG) begin
                     index <= 9'd0;
                     state <= DUMP_MEM;
                  end else begin
                     index <= index + 9'd1;
                  end
               end
            end
            DUMP_MEM: begin
               if (can_load && load_en)
                  index <= index + 9'd1;
               if (out_valid && out_ready && out_last) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef STATE_DUMP_PC_TRACE_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         trace_overflow <= 1'b0;
      else if (state == RUN && !can_load)
         trace_overflow <= 1'b1;
   end
`else
   logic unused_pc;
   assign unused_pc = ^pc;
`endif

   dump_out_stage u_out_stage (
      .clk       (clk),
      .reset     (reset),
      .load_en   (load_en),
      .load_tag  (load_tag),
      .load_data (load_data),
      .load_last (load_last),
      .out_ready (out_ready),
      .can_load  (can_load),
      .out_valid (out_valid),
      .out_tag   (out_tag),
      .out_data  (out_data),
      .out_last  (out_last)
   );

endmodule

// File: tb/tb_state_dump_unit.sv
// Randomized bench for state_dump_unit: register file and memory models, expected-record queue.
// Covers the STATE_DUMP_PC_TRACE_EN build when that macro is defined.
module tb_state_dump_unit;
   import state_dump_pkg::*;

   localparam logic [31:0] MEM_BASE       = 32'h4000;
   localparam int          MEM_WORDS      = 4;
   localparam int          TIMEOUT_CYCLES = 64;
   localparam int          DUMP_RECORDS   = NUM_REGS + MEM_WORDS;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] inst = 32'h1;
   logic [31:0] pc = 32'h0;
   logic        halt_req;
   logic [4:0]  rf_raddr;
   logic [31:0] rf_rdata;
   logic [31:0] mem_raddr;
   logic [7:0]  mem_rdata;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [1:0]  out_tag;
   logic [31:0] out_data;
   logic        out_last;
   logic [1:0]  halt_cause;
   logic        done;
`ifdef STATE_DUMP_PC_TRACE_EN
   logic        trace_overflow;
`endif

   logic [31:0] rf [NUM_REGS];
   logic [7:0]  mem [MEM_WORDS];
   logic [31:0] mem_off;

   int          checks = 0;
   int          failures = 0;
   logic [34:0] exp_q [$];
   bit          monitor_on = 1'b0;
   int          xfer_count = 0;
   bit          pc_strict = 1'b0;
   bit          have_prev_pc = 1'b0;
   logic [31:0] prev_pc = 32'h0;

   always #5 clk = ~clk;

   assign rf_rdata = rf[rf_raddr];

   always_comb begin
      mem_off   = mem_raddr - MEM_BASE;
      mem_rdata = 8'h00;
      if (mem_off < 32'(MEM_WORDS))
         mem_rdata = mem[mem_off[1:0]];
   end

   state_dump_unit #(
      .MEM_BASE       (MEM_BASE),
      .MEM_WORDS      (MEM_WORDS),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .inst       (inst),
      .pc         (pc),
      .halt_req   (halt_req),
      .rf_raddr   (rf_raddr),
      .rf_rdata   (rf_rdata),
      .mem_raddr  (mem_raddr),
      .mem_rdata  (mem_rdata),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_tag    (out_tag),
      .out_data   (out_data),
      .out_last   (out_last),
      .halt_cause (halt_cause),
      .done       (done)
`ifdef STATE_DUMP_PC_TRACE_EN
      ,
      .trace_overflow (trace_overflow)
`endif
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   // The dump is fully determined by register and memory contents at halt time.
   task automatic buildExpected();
      exp_q.delete();
      xfer_count = 0;
      for (int i = 0; i < NUM_REGS; i++)
         exp_q.push_back({1'b0, TAG_REG, rf[i]});
      for (int j = 0; j < MEM_WORDS; j++)
         exp_q.push_back({(j == MEM_WORDS - 1), TAG_MEM, 24'd0, mem[j]});
   endtask

   task automatic checkRecord();
      logic [34:0] e;
      if (exp_q.size() == 0) begin
         checkOutput("unexpected_valid", 32'(out_valid), 32'd0);
      end else begin
         e = exp_q[0];
         checkOutput($sformatf("rec%0d_tag", xfer_count), 32'(out_tag), 32'(e[33:32]));
         checkOutput($sformatf("rec%0d_data", xfer_count), out_data, e[31:0]);
         checkOutput($sformatf("rec%0d_last", xfer_count), 32'(out_last), 32'(e[34]));
         if (out_ready) begin
            void'(exp_q.pop_front());
            xfer_count++;
         end
      end
   endtask

   task automatic checkPcRecord();
      if (pc_strict && have_prev_pc)
         checkOutput("pc_sequence", out_data, prev_pc + 32'd4);
      if (out_ready) begin
         prev_pc      = out_data;
         have_prev_pc = 1'b1;
      end
   endtask

   // Inputs change on the falling edge, so the stream is observed in a stable window before each rising edge.
   always @(negedge clk) begin
      #2;
      if (monitor_on && out_valid) begin
`ifdef STATE_DUMP_PC_TRACE_EN
         if (out_tag == TAG_PC) checkPcRecord();
         else
`endif
         checkRecord();
      end
   end

   task automatic applyStimulus(input logic [31:0] inst_v, input logic ready_v);
      @(negedge clk);
      inst      = inst_v;
      out_ready = ready_v;
      pc        = pc + 32'd4;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] nonZeroInst();
      return $urandom() | 32'h0000_0001;
   endfunction

   task automatic checkResetState(input string where);
      checkOutput({where, "_halt_req"}, 32'(halt_req), 32'd0);
      checkOutput({where, "_out_valid"}, 32'(out_valid), 32'd0);
      checkOutput({where, "_out_tag"}, 32'(out_tag), 32'd0);
      checkOutput({where, "_out_data"}, out_data, 32'd0);
      checkOutput({where, "_out_last"}, 32'(out_last), 32'd0);
      checkOutput({where, "_halt_cause"}, 32'(halt_cause), 32'd0);
      checkOutput({where, "_done"}, 32'(done), 32'd0);
      checkOutput({where, "_rf_raddr"}, 32'(rf_raddr), 32'd0);
      checkOutput({where, "_mem_raddr"}, mem_raddr, MEM_BASE);
`ifdef STATE_DUMP_PC_TRACE_EN
      checkOutput({where, "_trace_overflow"}, 32'(trace_overflow), 32'd0);
`endif
   endtask

   task automatic randomContents();
      for (int i = 0; i < NUM_REGS; i++) rf[i] = $urandom();
      mem[0] = 8'hAA; mem[1] = 8'hBB; mem[2] = 8'hCC; mem[3] = 8'hDD;
   endtask

   task automatic restart();
      reset      = 1'b1;
      monitor_on = 1'b0;
      repeat (2) @(negedge clk);
      checkResetState("reset");
      buildExpected();
      pc           = 32'h003F_FFFC;
      inst         = nonZeroInst();
      have_prev_pc = 1'b0;
      @(posedge clk);
      #1;
      reset      = 1'b0;
      monitor_on = 1'b1;
   endtask

   task automatic runDump(input bit random_ready, input string name);
      int budget;
      budget = 0;
      while (exp_q.size() != 0 && budget < 400) begin
         applyStimulus(nonZeroInst(), random_ready ? 1'($urandom_range(0, 1)) : 1'b1);
         budget++;
      end
      checkOutput({name, "_records_left"}, 32'(exp_q.size()), 32'd0);
      checkOutput({name, "_done"}, 32'(done), 32'd1);
      checkOutput({name, "_valid_after_last"}, 32'(out_valid), 32'd0);
      checkOutput({name, "_halt_req_held"}, 32'(halt_req), 32'd1);
   endtask

   initial begin
      int cycles;
      #1;
      checkResetState("power_on");

      // Zero-instruction halt with a fixed register image and an always-ready consumer.
      for (int i = 0; i < NUM_REGS; i++) rf[i] = 32'(i * 3);
      rf[2] = 32'h0040_0024;
      mem[0] = 8'hAA; mem[1] = 8'hBB; mem[2] = 8'hCC; mem[3] = 8'hDD;
      restart();
      for (int k = 0; k < 10; k++) begin
         applyStimulus(nonZeroInst(), 1'b1);
         checkOutput("zero_pre_halt_req", 32'(halt_req), 32'd0);
`ifndef STATE_DUMP_PC_TRACE_EN
         checkOutput("zero_run_valid", 32'(out_valid), 32'd0);
`endif
      end
      applyStimulus(32'd0, 1'b1);
      checkOutput("zero_halt_req", 32'(halt_req), 32'd1);
      checkOutput("zero_halt_cause", 32'(halt_cause), 32'(CAUSE_ZERO_INST));
      applyStimulus(nonZeroInst(), 1'b1);
      checkOutput("zero_first_valid", 32'(out_valid), 32'd1);
      checkOutput("zero_first_tag", 32'(out_tag), 32'(TAG_REG));
      checkOutput("zero_first_data", out_data, 32'd0);
      cycles = 1;
      while (!done && cycles < 200) begin
         applyStimulus(nonZeroInst(), 1'b1);
         cycles++;
      end
      checkOutput("zero_dump_cycles", 32'(cycles), 32'(DUMP_RECORDS + 1));
      checkOutput("zero_records_left", 32'(exp_q.size()), 32'd0);
      checkOutput("zero_valid_after_last", 32'(out_valid), 32'd0);

      // Timeout halt with random registers and a stalling consumer.
      randomContents();
      restart();
      for (int k = 1; k <= TIMEOUT_CYCLES; k++) begin
         applyStimulus(nonZeroInst(), 1'b1);
         checkOutput($sformatf("timeout_halt_req_c%0d", k), 32'(halt_req), 32'(k >= TIMEOUT_CYCLES));
      end
      checkOutput("timeout_halt_cause", 32'(halt_cause), 32'(CAUSE_TIMEOUT));
      runDump(1'b1, "timeout");

      // Zero instruction arriving on the timeout cycle wins.
      randomContents();
      restart();
      for (int k = 1; k < TIMEOUT_CYCLES; k++) applyStimulus(nonZeroInst(), 1'b1);
      checkOutput("simul_pre_halt_req", 32'(halt_req), 32'd0);
      applyStimulus(32'd0, 1'b1);
      checkOutput("simul_halt_req", 32'(halt_req), 32'd1);
      checkOutput("simul_halt_cause", 32'(halt_cause), 32'(CAUSE_ZERO_INST));
      runDump(1'b1, "simul");

      // Reset asserted between clock edges after the eleventh transfer.
      randomContents();
      restart();
      repeat (3) applyStimulus(nonZeroInst(), 1'b1);
      applyStimulus(32'd0, 1'b1);
      cycles = 0;
      while (xfer_count < 11 && cycles < 200) begin
         applyStimulus(nonZeroInst(), 1'($urandom_range(0, 1)));
         cycles++;
      end
      checkOutput("midreset_reached_11", 32'(xfer_count), 32'd11);
      monitor_on = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      checkResetState("midreset");
      randomContents();
      restart();
      repeat (2) applyStimulus(nonZeroInst(), 1'b1);
      applyStimulus(32'd0, 1'b1);
      checkOutput("rerun_halt_cause", 32'(halt_cause), 32'(CAUSE_ZERO_INST));
      runDump(1'b1, "rerun");

`ifdef STATE_DUMP_PC_TRACE_EN
      // PC trace: consecutive PCs while ready, then a single stall makes overflow sticky.
      randomContents();
      restart();
      pc_strict = 1'b1;
      repeat (8) applyStimulus(nonZeroInst(), 1'b1);
      checkOutput("trace_pc_seen", 32'(have_prev_pc), 32'd1);
      checkOutput("trace_no_overflow", 32'(trace_overflow), 32'd0);
      pc_strict = 1'b0;
      applyStimulus(nonZeroInst(), 1'b0);
      applyStimulus(nonZeroInst(), 1'b1);
      checkOutput("trace_overflow_set", 32'(trace_overflow), 32'd1);
      repeat (3) applyStimulus(nonZeroInst(), 1'b1);
      applyStimulus(32'd0, 1'b1);
      runDump(1'b1, "trace");
      checkOutput("trace_overflow_sticky", 32'(trace_overflow), 32'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/state_dump_unit.md
Name: state_dump_unit

Overview:
- Hardware producer of the end-of-run architectural state stream for the single-cycle machine.
- Watches the fetched instruction and a cycle budget, then freezes the machine.
- Scans out all 32 register-file entries and a window of data-memory bytes over a valid/ready stream.
- Sits beside the machine, on the rf and data_memory debug read ports; the stream consumer is a host link or bench monitor.

Parameters:
- MEM_BASE, 32'h4000, byte address of the first data-memory byte dumped.
- MEM_WORDS, 4, number of consecutive bytes dumped; must be 1..256.
- TIMEOUT_CYCLES, 64, run cycles after reset release before a forced halt; must be at least 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- inst  input  32  instruction fetched this cycle by the machine.
- pc  input  32  current byte PC of the machine.
- halt_req  output  1  freeze request to the machine (PC/regfile/memory write enables gated off).
- rf_raddr  output  5  register-file debug read address; read is combinational.
- rf_rdata  input  32  register-file debug read data.
- mem_raddr  output  32  data-memory debug byte read address; read is combinational.
- mem_rdata  input  8  data-memory debug read byte.
- out_valid  output  1  stream record valid.
- out_ready  input  1  consumer ready.
- out_tag  output  2  record kind: 0 PC, 1 register, 2 memory.
- out_data  output  32  record payload.
- out_last  output  1  final record of the dump.
- halt_cause  output  2  0 none, 1 zero instruction, 2 timeout.
- done  output  1  dump complete; holds until reset.

Behaviour:
- Reset (async, takes effect immediately) puts every output at 0, state RUN, cycle counter 0, index 0.
  - mem_raddr = MEM_BASE is combinational from index 0; it is the only non-zero value.
- States: RUN -> DUMP_REG -> DUMP_MEM -> DONE. There is no exit from DONE except reset.
- RUN:
  - Counter increments every cycle.
  - Trigger at a rising edge when inst == 0, or when counter == TIMEOUT_CYCLES-1.
  - If both hold in the same cycle, halt_cause = 1 (zero-instruction priority).
  - On trigger: state goes to DUMP_REG, halt_req goes to 1 and stays at 1 until reset, index clears to 0.
- Output stage: a single register.
  - It loads when out_valid == 0 or out_ready == 1.
  - A record is transferred on a cycle with out_valid && out_ready.
  - out_data, out_tag and out_last hold stable while out_valid && !out_ready.
- DUMP_REG:
  - rf_raddr = index.
  - On each load, out_data <= rf_rdata, out_tag <= 1, and index increments.
  - After index 31 is loaded, index clears and state goes to DUMP_MEM.
- DUMP_MEM:
  - mem_raddr = MEM_BASE + index (32-bit add, wraps modulo 2^32).
  - out_data <= {24'b0, mem_rdata}, out_tag <= 2.
  - out_last <= 1 on the load of index MEM_WORDS-1.
- Transition to DONE happens on the handshake of the out_last record: done goes to 1 and out_valid drops to 0 that edge.
- Latency and throughput:
  - Trigger at edge E0.
  - First register record is valid after E1.
  - With out_ready held at 1, one record per cycle; the total dump is 32 + MEM_WORDS records.
- The dump is never re-triggered; inst and the counter are ignored outside RUN.
- Reset mid-dump aborts immediately. No partial record is retained. After release the block is in RUN with counter 0.

Optional Feature:
- Macro: STATE_DUMP_PC_TRACE_EN.
- Defined:
  - In RUN, the output stage loads a PC record (tag 0, out_data = pc) every cycle it is able to load.
  - If the stage cannot load (out_valid && !out_ready), that cycle's PC is dropped and a sticky trace_overflow output goes to 1.
  - A pending PC record must complete its handshake before the first register record loads.
- Undefined:
  - No tag-0 records are ever produced.
  - trace_overflow is absent from the port list.
  - Out_valid stays 0 throughout RUN.

Decomposition:
- Package state_dump_pkg holds:
  - the state enum (RUN, DUMP_REG, DUMP_MEM, DONE);
  - tag constants TAG_PC = 0, TAG_REG = 1, TAG_MEM = 2;
  - halt-cause constants;
  - the NUM_REGS = 32 constant.
- One sub-module, dump_out_stage: the valid/ready output register holding tag, data and last, with a load_en/load inputs interface.
- FSM, counter and index logic stay in state_dump_unit.

Test Plan:
- Zero-instruction halt: inst nonzero for 10 cycles, then 0, out_ready = 1; rf[i] preloaded with i*3 and rf[2] = 32'h00400024.
  - halt_req rises the next edge; halt_cause = 1.
  - 32 tag-1 records: record 2 = 32'h00400024, record 31 = 93.
- Timeout: inst never 0, TIMEOUT_CYCLES = 64.
  - Trigger on cycle 64 after reset release; halt_cause = 2.
- Simultaneous triggers: inst == 0 on cycle 64 -> halt_cause = 1.
- Backpressure: memory bytes at 0x4000..0x4003 = AA, BB, CC, DD; out_ready toggled 1-0-0-1 randomly.
  - Memory records are 32'h000000AA .. 32'h000000DD in order.
  - Payload is held stable while stalled.
  - out_last is set only with DD, then done = 1 and out_valid = 0.
- Reset mid-dump: assert reset after record 10 (record 10 is the eleventh transfer, index 10).
  - All outputs are 0 immediately (asynchronous); mem_raddr = MEM_BASE.
  - Re-run produces the full 36-record dump from index 0.
- With STATE_DUMP_PC_TRACE_EN: out_ready = 1, pc stepping 0x00400000 +4.
  - Tag-0 records carry consecutive PCs.
  - Dropping out_ready for one RUN cycle sets trace_overflow = 1, and it stays set.
